// File: rtl/ifu_prefetch_if.sv
// AXI4 read-address and read-data channels between the fetch unit and the interconnect.
interface ifu_prefetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid;
    logic              rready;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;
    logic              rlast;
    logic [3:0]        rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rresp, rdata, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rresp, rdata, rlast, rid
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: one AXI4 INCR burst in flight, beats split into 32-bit words
// and queued in a first-word-fall-through FIFO towards decode.
module ifu_prefetch #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 64,
    parameter int unsigned       BURST_LEN  = 4,
    parameter int unsigned       FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h8000_0000,
    parameter logic [3:0]        AXI_ID     = 4'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    ifu_prefetch_if.master    io_master,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault
);
    localparam int unsigned       WPB         = DATA_W / 32;
    localparam int unsigned       BYTES       = DATA_W / 8;
    localparam int unsigned       LGB         = $clog2(BYTES);
    localparam int unsigned       SKW         = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int unsigned       PW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned       CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned       BURST_WORDS = BURST_LEN * WPB;
    localparam logic [PW-1:0]     PMASK       = PW'(FIFO_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BYTES);

    typedef enum logic [2:0] {StIdle, StAr, StData, StDrain, StHalt} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] fpc_q, araddr_q, raddr_q;
    logic [SKW-1:0]    skip_q;
    logic              first_q, fault_q, redir_q, arvalid_q, rready_q;

    logic [31:0]       mem_word_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_pc_q    [FIFO_DEPTH];
    logic              mem_fault_q [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q;

    logic              push_beat, pop, room, beat_err;
    logic [WPB-1:0]    lane_en;
    logic [PW-1:0]     lane_idx [WPB];
    logic [CW-1:0]     n_push;

    // rid is never needed: only one burst is ever outstanding.
    logic unused_rid;
    assign unused_rid = ^io_master.rid;

    assign io_master.arvalid = arvalid_q;
    assign io_master.araddr  = araddr_q;
    assign io_master.arid    = AXI_ID;
    assign io_master.arlen   = 8'(BURST_LEN - 1);
    assign io_master.arsize  = 3'(LGB);
    assign io_master.arburst = 2'b01;
    assign io_master.rready  = rready_q;

    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid && inst_ready;
    assign room       = (CW'(FIFO_DEPTH) - count_q) >= CW'(BURST_WORDS);
    assign beat_err   = (io_master.rresp != 2'b00);

    // Select which lanes of the current beat are queued and the slot each one lands in.
    always_comb begin
        push_beat = (state_q == StData) && io_master.rvalid && !redirect_valid;
        n_push    = '0;
        for (int k = 0; k < WPB; k++) begin
            lane_en[k]  = push_beat && !(first_q && (k < int'(skip_q)));
            lane_idx[k] = (wptr_q + PW'(n_push)) & PMASK;
            if (lane_en[k]) n_push = n_push + 1'b1;
        end
    end

    // FIFO storage; contents are qualified by count_q so no reset is needed.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WPB; k++) begin
            if (lane_en[k]) begin
                mem_word_q[lane_idx[k]]  <= io_master.rdata[32*k +: 32];
                mem_pc_q[lane_idx[k]]    <= raddr_q + ADDR_W'(4 * k);
                mem_fault_q[lane_idx[k]] <= beat_err;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue and drops any pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (redirect_valid) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= (wptr_q + PW'(n_push)) & PMASK;
            rptr_q  <= pop ? ((rptr_q + 1'b1) & PMASK) : rptr_q;
            count_q <= count_q + n_push - CW'(pop);
        end
    end

    // Head entry drives decode; forced to zero while the FIFO is empty.
    always_comb begin
        inst       = '0;
        inst_pc    = '0;
        inst_fault = 1'b0;
        if (inst_valid) begin
            inst       = mem_word_q[rptr_q];
            inst_pc    = mem_pc_q[rptr_q];
            inst_fault = mem_fault_q[rptr_q];
        end
    end

    // Fetch sequencer with registered AR/R handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            fpc_q     <= RESET_PC;
            araddr_q  <= '0;
            raddr_q   <= '0;
            skip_q    <= '0;
            first_q   <= 1'b0;
            fault_q   <= 1'b0;
            redir_q   <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            if (redirect_valid) fpc_q <= redirect_pc;
            unique case (state_q)
                StIdle: begin
                    if (!redirect_valid && room) begin
                        state_q   <= StAr;
                        araddr_q  <= fpc_q & ALIGN_MASK;
                        raddr_q   <= fpc_q & ALIGN_MASK;
                        skip_q    <= SKW'((fpc_q >> 2) & ADDR_W'(WPB - 1));
                        arvalid_q <= 1'b1;
                    end
                end
                StAr: begin
                    // An issued AR cannot be withdrawn; a redirect only retargets its data.
                    if (io_master.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        first_q   <= 1'b1;
                        fault_q   <= 1'b0;
                        redir_q   <= 1'b0;
                        state_q   <= (redir_q || redirect_valid) ? StDrain : StData;
                    end else if (redirect_valid) begin
                        redir_q <= 1'b1;
                    end
                end
                StData: begin
                    if (io_master.rvalid) begin
                        first_q <= 1'b0;
                        raddr_q <= raddr_q + ADDR_W'(BYTES);
                        if (redirect_valid) begin
                            state_q <= io_master.rlast ? StIdle : StDrain;
                            if (io_master.rlast) rready_q <= 1'b0;
                        end else if (io_master.rlast) begin
                            fpc_q    <= araddr_q + BURST_BYTES;
                            rready_q <= 1'b0;
                            state_q  <= (fault_q || beat_err) ? StHalt : StIdle;
                        end else begin
                            fault_q <= fault_q || beat_err;
                        end
                    end else if (redirect_valid) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (io_master.rvalid && io_master.rlast) begin
                        state_q  <= StIdle;
                        rready_q <= 1'b0;
                    end
                end
                StHalt: begin
                    if (redirect_valid) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: reset fetch, backpressure, redirects, fault and HALT.
module tb_ifu_prefetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    int checks = 0;
    int errors = 0;

    ifu_prefetch_if #(.ADDR_W(32), .DATA_W(64)) axi ();

    ifu_prefetch #(
        .ADDR_W(32), .DATA_W(64), .BURST_LEN(4), .FIFO_DEPTH(8),
        .RESET_PC(32'h8000_0000), .AXI_ID(4'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .io_master(axi),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_fault(inst_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ar(input logic [31:0] exp_addr, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (axi.arvalid === 1'b1) seen = 1'b1;
        end
        check({tag, "_arvalid"}, 64'(seen), 64'd1);
        check({tag, "_araddr"}, 64'(axi.araddr), 64'(exp_addr));
    endtask

    task automatic accept_ar();
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] addr, input logic [1:0] resp, input logic last,
                             input string tag);
        bit ok = 1'b0;
        axi.rvalid = 1'b1;
        axi.rdata  = {word(addr + 32'd4), word(addr)};
        axi.rresp  = resp;
        axi.rlast  = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (axi.rready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'b00;
        check({tag, "_accepted"}, 64'(ok), 64'd1);
    endtask

    task automatic pop_check(input logic [31:0] exp_pc, input logic exp_fault, input string tag);
        check({tag, "_valid"}, 64'(inst_valid), 64'd1);
        check({tag, "_pc"}, 64'(inst_pc), 64'(exp_pc));
        check({tag, "_inst"}, 64'(inst), 64'(word(exp_pc)));
        check({tag, "_fault"}, 64'(inst_fault), 64'(exp_fault));
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
    endtask

    initial begin
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rresp   = 2'b00;
        axi.rdata   = '0;
        axi.rlast   = 1'b0;
        axi.rid     = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_arvalid", 64'(axi.arvalid), 64'd0);
        check("rst_rready", 64'(axi.rready), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_araddr", 64'(axi.araddr), 64'd0);
        check("rst_arlen", 64'(axi.arlen), 64'd3);
        check("rst_arsize", 64'(axi.arsize), 64'd3);
        check("rst_arburst", 64'(axi.arburst), 64'd1);
        check("rst_arid", 64'(axi.arid), 64'd0);
        rst = 1'b1;

        // Reset fetch: 8 words from 0x8000_0000 under full backpressure
        wait_ar(32'h8000_0000, "t1");
        accept_ar();
        send_beat(32'h8000_0000, 2'b00, 1'b0, "t1_b0");
        check("t1_first_valid", 64'(inst_valid), 64'd1);
        check("t1_first_pc", 64'(inst_pc), 64'h8000_0000);
        for (int b = 1; b < 4; b++)
            send_beat(32'h8000_0000 + 32'(8 * b), 2'b00, (b == 3), $sformatf("t1_b%0d", b));
        repeat (4) @(negedge clk);
        check("t1_full_no_ar", 64'(axi.arvalid), 64'd0);
        for (int i = 0; i < 7; i++)
            pop_check(32'h8000_0000 + 32'(4 * i), 1'b0, $sformatf("t1_pop%0d", i));
        repeat (3) @(negedge clk);
        check("t1_one_free_no_ar", 64'(axi.arvalid), 64'd0);
        pop_check(32'h8000_001C, 1'b0, "t1_pop7");
        wait_ar(32'h8000_0020, "t1_second");

        // Redirect mid-burst to an unaligned target, landing on beat 1
        accept_ar();
        send_beat(32'h8000_0020, 2'b00, 1'b0, "t2_b0");
        check("t2_b0_valid", 64'(inst_valid), 64'd1);
        check("t2_rready_before", 64'(axi.rready), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0104;
        axi.rvalid     = 1'b1;
        axi.rdata      = {word(32'h8000_002C), word(32'h8000_0028)};
        @(negedge clk);
        redirect_valid = 1'b0;
        axi.rvalid     = 1'b0;
        check("t2_flushed", 64'(inst_valid), 64'd0);
        check("t2_drain_rready", 64'(axi.rready), 64'd1);
        send_beat(32'h8000_0030, 2'b00, 1'b0, "t2_b2");
        check("t2_b2_not_pushed", 64'(inst_valid), 64'd0);
        send_beat(32'h8000_0038, 2'b00, 1'b1, "t2_b3");
        check("t2_b3_not_pushed", 64'(inst_valid), 64'd0);
        wait_ar(32'h8000_0100, "t2_redir");
        check("t2_no_stale", 64'(inst_valid), 64'd0);
        accept_ar();
        for (int b = 0; b < 4; b++)
            send_beat(32'h8000_0100 + 32'(8 * b), 2'b00, (b == 3), $sformatf("t2_nb%0d", b));
        for (int i = 0; i < 7; i++)
            pop_check(32'h8000_0104 + 32'(4 * i), 1'b0, $sformatf("t2_pop%0d", i));
        check("t2_seven_only", 64'(inst_valid), 64'd0);
        wait_ar(32'h8000_0120, "t2_next");

        // Redirect while AR is stalled: AR held stable, burst drained without pushes
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_hold_arvalid%0d", i), 64'(axi.arvalid), 64'd1);
            check($sformatf("t3_hold_araddr%0d", i), 64'(axi.araddr), 64'h8000_0120);
            @(negedge clk);
        end
        accept_ar();
        for (int b = 0; b < 4; b++) begin
            send_beat(32'h8000_0120 + 32'(8 * b), 2'b00, (b == 3), $sformatf("t3_b%0d", b));
            check($sformatf("t3_nopush%0d", b), 64'(inst_valid), 64'd0);
        end
        wait_ar(32'h8000_0400, "t3_new");

        // Fault on beats 2 and 3, then HALT until redirect
        accept_ar();
        send_beat(32'h8000_0400, 2'b00, 1'b0, "t4_b0");
        send_beat(32'h8000_0408, 2'b00, 1'b0, "t4_b1");
        send_beat(32'h8000_0410, 2'b10, 1'b0, "t4_b2");
        send_beat(32'h8000_0418, 2'b10, 1'b1, "t4_b3");
        for (int i = 0; i < 8; i++)
            pop_check(32'h8000_0400 + 32'(4 * i), (i >= 4), $sformatf("t4_pop%0d", i));
        repeat (5) @(negedge clk);
        check("t4_halt_no_ar", 64'(axi.arvalid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0800;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_ar(32'h8000_0800, "t4_after_halt");
        accept_ar();
        send_beat(32'h8000_0800, 2'b00, 1'b0, "t5_b0");
        check("t5_valid_before_rst", 64'(inst_valid), 64'd1);

        // Asynchronous reset mid-burst clears outputs without a clock edge
        #2 rst = 1'b0;
        #1;
        check("t5_rst_arvalid", 64'(axi.arvalid), 64'd0);
        check("t5_rst_rready", 64'(axi.rready), 64'd0);
        check("t5_rst_araddr", 64'(axi.araddr), 64'd0);
        check("t5_rst_inst_valid", 64'(inst_valid), 64'd0);
        check("t5_rst_inst", 64'(inst), 64'd0);
        check("t5_rst_inst_pc", 64'(inst_pc), 64'd0);
        check("t5_rst_inst_fault", 64'(inst_fault), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
